adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15, number of WAIT cycles without ack before a result is dropped; legal range 1..255.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; low clears all state immediately, independent of clk.
REQ-004 req0  input  1  requester 0 asks for one addition; level, sampled only in IDLE.
REQ-005 a0, b0  input  4 each  requester 0 unsigned operands.
REQ-006 req1  input  1  requester 1 asks for one addition; level, sampled only in IDLE.
REQ-007 a1, b1  input  4 each  requester 1 unsigned operands.
REQ-008 ack  input  1  consumer accepts the current result; honoured only in WAIT.
REQ-009 gnt0, gnt1  output  1 each  one-cycle grant pulse: operands of that requester captured.
REQ-010 res  output  5  registered unsigned sum; bit 4 is the carry.
REQ-011 res_valid  output  1  res and res_id are valid.
REQ-012 res_id  output  1  requester owning res (0 or 1).
REQ-013 carry_cnt  output  4  count of results with res[4]=1; saturates at 15.
REQ-014 timeout_flag  output  1  sticky: at least one result was dropped on timeout.

Function
REQ-015 FSM states IDLE, ADD, WAIT; the block SHALL hold exactly one state per cycle.
REQ-016 IDLE, no req: remain IDLE; gnt0=gnt1=0.
REQ-017 IDLE, one req: at the edge, capture that requester's a/b, pulse its gnt for the following cycle, go ADD.
REQ-018 IDLE, req0 and req1 both high: grant the requester not served last (round robin); last-served pointer resets to 1, so req0 wins the first contest.
REQ-019 ADD: at the edge, res <= zero-extended a + zero-extended b (5-bit, no truncation), res_id <= granted requester, res_valid <= 1, go WAIT; latency from req sampled in IDLE to res_valid high = 2 edges.
REQ-020 ADD: if the new res[4]=1 and carry_cnt<15, carry_cnt increments at the same edge; at 15 it holds.
REQ-021 WAIT: res, res_id, res_valid held stable; wait counter increments each cycle from 0.
REQ-022 WAIT with ack=1: at the edge res_valid <= 0, last-served <= res_id, go IDLE; res keeps its value.
REQ-023 WAIT, counter reaching TIMEOUT with ack=0: res_valid <= 0, timeout_flag <= 1, last-served <= res_id, go IDLE.
REQ-024 ack and timeout in the same cycle: ack wins, timeout_flag unchanged.
REQ-025 ack in IDLE or ADD: ignored, no state effect.
REQ-026 req toggling or operand change after grant: no effect on the in-flight result.
REQ-027 Minimum spacing between successive grants: 3 cycles (IDLE, ADD, WAIT with immediate ack).
REQ-028 gnt0 and gnt1 SHALL never be high in the same cycle; at most one result in flight.

Reset
REQ-029 reset low: state IDLE, gnt0=gnt1=0, res=0, res_valid=0, res_id=0, carry_cnt=0, timeout_flag=0, wait counter=0, last-served=1, captured operands=0.
REQ-030 reset low mid-ADD or mid-WAIT: in-flight operation discarded, no ack required, no flag set; first request after release is arbitrated as after power-up.
REQ-031 reset release: first state update on the first rising clk edge with reset high.

Verification
REQ-032 Single req0 with a0=9, b0=8, ack at first WAIT cycle -> gnt0 pulse, res=5'h11, res_id=0, res_valid high 1 cycle, carry_cnt=1.
REQ-033 req0 and req1 held high, a0=1,b0=2, a1=15,b1=15, ack immediate -> grants alternate 0,1,0,1; results 3, 30, 3, 30; carry_cnt=2 after four results.
REQ-034 Single req1, a1=4, b1=4, ack never, TIMEOUT=15 -> res=8 valid for exactly 15 cycles, then res_valid=0, timeout_flag=1, FSM IDLE.
REQ-035 ack asserted in the cycle the wait counter hits TIMEOUT -> result accepted, timeout_flag stays 0.
REQ-036 Sixteen results with carry (a=15, b=1) -> carry_cnt saturates at 15, never wraps to 0.
REQ-037 reset pulsed low during WAIT with res=30 valid -> res_valid and res drop to 0 immediately, next contest with both req high grants requester 0.

Source files
------------

// File: rtl/adder_arbiter_if.sv
// Request/operand/result bundle between two requesters, one consumer and adder_arbiter.
interface adder_arbiter_if;
  logic       req0;
  logic [3:0] a0;
  logic [3:0] b0;
  logic       req1;
  logic [3:0] a1;
  logic [3:0] b1;
  logic       ack;
  logic       gnt0;
  logic       gnt1;
  logic [4:0] res;
  logic       res_valid;
  logic       res_id;
  logic [3:0] carry_cnt;
  logic       timeout_flag;

  modport master (
    output req0, a0, b0, req1, a1, b1, ack,
    input  gnt0, gnt1, res, res_valid, res_id, carry_cnt, timeout_flag
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1, ack,
    output gnt0, gnt1, res, res_valid, res_id, carry_cnt, timeout_flag
  );
endinterface

// File: rtl/adder_arbiter.sv
// Two-requester round-robin arbiter feeding a 4-bit adder; one result in flight,
// held until ack or dropped after TIMEOUT wait cycles.
module adder_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  adder_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ADD, WAIT} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t     state, state_next;
  logic [3:0] op_a, op_b;
  logic       op_id;
  logic       last_served;
  logic [7:0] wait_cnt;
  logic       gnt0, gnt1;
  logic [4:0] res;
  logic       res_valid, res_id;
  logic [3:0] carry_cnt;
  logic       timeout_flag;

  logic       any_req;
  logic       sel;
  logic       ack_take;
  logic       expire;
  logic [4:0] sum;

  always_comb begin
    any_req  = bus.req0 | bus.req1;
    // Contest goes to the side not served last; otherwise whoever is asking.
    sel      = (bus.req0 & bus.req1) ? ~last_served : bus.req1;
    ack_take = (state == WAIT) & bus.ack;
    expire   = (state == WAIT) & ~bus.ack & (wait_cnt == LAST_WAIT);
    sum      = {1'b0, op_a} + {1'b0, op_b};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ADD;
      ADD:     state_next = WAIT;
      WAIT:    if (ack_take || expire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_a         <= '0;
      op_b         <= '0;
      op_id        <= 1'b0;
      last_served  <= 1'b1;
      wait_cnt     <= '0;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      res          <= '0;
      res_valid    <= 1'b0;
      res_id       <= 1'b0;
      carry_cnt    <= '0;
      timeout_flag <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            op_a  <= sel ? bus.a1 : bus.a0;
            op_b  <= sel ? bus.b1 : bus.b0;
            op_id <= sel;
            gnt0  <= ~sel;
            gnt1  <= sel;
          end
        end
        ADD: begin
          res       <= sum;
          res_id    <= op_id;
          res_valid <= 1'b1;
          wait_cnt  <= '0;
          if (sum[4] && carry_cnt != 4'd15) carry_cnt <= carry_cnt + 4'd1;
        end
        WAIT: begin
          if (ack_take) begin
            res_valid   <= 1'b0;
            last_served <= res_id;
            wait_cnt    <= '0;
          end else if (expire) begin
            res_valid    <= 1'b0;
            last_served  <= res_id;
            timeout_flag <= 1'b1;
            wait_cnt     <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt0         = gnt0;
  assign bus.gnt1         = gnt1;
  assign bus.res          = res;
  assign bus.res_valid    = res_valid;
  assign bus.res_id       = res_id;
  assign bus.carry_cnt    = carry_cnt;
  assign bus.timeout_flag = timeout_flag;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: grant, add latency, round robin, timeout,
// carry saturation and asynchronous reset.
module tb_adder_arbiter;

  logic clk;
  logic reset;
  int unsigned vec;
  int unsigned err;
  int unsigned cnt;

  adder_arbiter_if bif ();

  adder_arbiter #(.TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    vec = 0;
    err = 0;
    reset = 1'b0;
    bif.req0 = 1'b0; bif.a0 = '0; bif.b0 = '0;
    bif.req1 = 1'b0; bif.a1 = '0; bif.b1 = '0;
    bif.ack  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt0", 8'(bif.gnt0), 8'd0);
    chk("rst_gnt1", 8'(bif.gnt1), 8'd0);
    chk("rst_res", 8'(bif.res), 8'd0);
    chk("rst_valid", 8'(bif.res_valid), 8'd0);
    chk("rst_id", 8'(bif.res_id), 8'd0);
    chk("rst_carry", 8'(bif.carry_cnt), 8'd0);
    chk("rst_flag", 8'(bif.timeout_flag), 8'd0);
    reset = 1'b1;

    // ack while idle does nothing
    bif.ack = 1'b1;
    repeat (2) @(negedge clk);
    chk("ack_idle_valid", 8'(bif.res_valid), 8'd0);
    chk("ack_idle_gnt0", 8'(bif.gnt0), 8'd0);
    bif.ack = 1'b0;

    // single req0, 9+8, operands changed after grant
    bif.req0 = 1'b1; bif.a0 = 4'd9; bif.b0 = 4'd8;
    @(negedge clk);
    chk("t1_gnt0", 8'(bif.gnt0), 8'd1);
    chk("t1_gnt1", 8'(bif.gnt1), 8'd0);
    chk("t1_valid_early", 8'(bif.res_valid), 8'd0);
    bif.req0 = 1'b0; bif.a0 = 4'd0; bif.b0 = 4'd0;
    @(negedge clk);
    chk("t1_gnt0_pulse", 8'(bif.gnt0), 8'd0);
    chk("t1_res", 8'(bif.res), 8'h11);
    chk("t1_id", 8'(bif.res_id), 8'd0);
    chk("t1_valid", 8'(bif.res_valid), 8'd1);
    chk("t1_carry", 8'(bif.carry_cnt), 8'd1);
    bif.ack = 1'b1;
    @(negedge clk);
    bif.ack = 1'b0;
    chk("t1_valid_drop", 8'(bif.res_valid), 8'd0);
    chk("t1_res_hold", 8'(bif.res), 8'h11);

    // both requesting: alternate 0,1,0,1 from reset
    pulse_reset();
    bif.req0 = 1'b1; bif.a0 = 4'd1;  bif.b0 = 4'd2;
    bif.req1 = 1'b1; bif.a1 = 4'd15; bif.b1 = 4'd15;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_gnt0", 8'(bif.gnt0), (i % 2 == 0) ? 8'd1 : 8'd0);
      chk("rr_gnt1", 8'(bif.gnt1), (i % 2 == 1) ? 8'd1 : 8'd0);
      @(negedge clk);
      chk("rr_res", 8'(bif.res), (i % 2 == 1) ? 8'd30 : 8'd3);
      chk("rr_id", 8'(bif.res_id), 8'(i % 2));
      bif.ack = 1'b1;
      @(negedge clk);
      bif.ack = 1'b0;
      chk("rr_carry", 8'(bif.carry_cnt), 8'((i + 1) / 2));
    end
    bif.req0 = 1'b0; bif.req1 = 1'b0;

    // req1 4+4, never acked: valid exactly 15 cycles then dropped
    pulse_reset();
    bif.req1 = 1'b1; bif.a1 = 4'd4; bif.b1 = 4'd4;
    @(negedge clk);
    chk("to_gnt1", 8'(bif.gnt1), 8'd1);
    bif.req1 = 1'b0;
    @(negedge clk);
    chk("to_res", 8'(bif.res), 8'd8);
    cnt = 0;
    for (int i = 0; i < 40 && bif.res_valid === 1'b1; i++) begin
      cnt++;
      @(negedge clk);
    end
    chk("to_valid_cycles", 8'(cnt), 8'd15);
    chk("to_valid_off", 8'(bif.res_valid), 8'd0);
    chk("to_flag", 8'(bif.timeout_flag), 8'd1);
    bif.req0 = 1'b1; bif.a0 = 4'd1; bif.b0 = 4'd1;
    @(negedge clk);
    chk("to_idle_gnt0", 8'(bif.gnt0), 8'd1);
    bif.req0 = 1'b0;
    @(negedge clk);
    bif.ack = 1'b1;
    @(negedge clk);
    bif.ack = 1'b0;
    chk("to_flag_sticky", 8'(bif.timeout_flag), 8'd1);

    // ack on the last wait cycle beats the timeout
    pulse_reset();
    bif.req0 = 1'b1; bif.a0 = 4'd2; bif.b0 = 4'd3;
    @(negedge clk);
    bif.req0 = 1'b0;
    @(negedge clk);
    repeat (14) @(negedge clk);
    chk("edge_valid_last", 8'(bif.res_valid), 8'd1);
    bif.ack = 1'b1;
    @(negedge clk);
    bif.ack = 1'b0;
    chk("edge_valid_off", 8'(bif.res_valid), 8'd0);
    chk("edge_flag", 8'(bif.timeout_flag), 8'd0);
    chk("edge_res", 8'(bif.res), 8'd5);

    // sixteen carries: counter saturates at 15
    for (int i = 0; i < 16; i++) begin
      bif.req0 = 1'b1; bif.a0 = 4'd15; bif.b0 = 4'd1;
      @(negedge clk);
      bif.req0 = 1'b0;
      @(negedge clk);
      chk("sat_res", 8'(bif.res), 8'd16);
      bif.ack = 1'b1;
      @(negedge clk);
      bif.ack = 1'b0;
      chk("sat_carry", 8'(bif.carry_cnt), (i >= 14) ? 8'd15 : 8'(i + 1));
    end

    // reset mid-WAIT clears immediately; next contest goes to requester 0
    pulse_reset();
    bif.req1 = 1'b1; bif.a1 = 4'd15; bif.b1 = 4'd15;
    @(negedge clk);
    bif.req1 = 1'b0;
    @(negedge clk);
    chk("ar_res_pre", 8'(bif.res), 8'd30);
    chk("ar_valid_pre", 8'(bif.res_valid), 8'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", 8'(bif.res_valid), 8'd0);
    chk("ar_res", 8'(bif.res), 8'd0);
    chk("ar_id", 8'(bif.res_id), 8'd0);
    @(negedge clk);
    reset = 1'b1;
    bif.req0 = 1'b1; bif.a0 = 4'd1; bif.b0 = 4'd2;
    bif.req1 = 1'b1;
    @(negedge clk);
    chk("ar_gnt0", 8'(bif.gnt0), 8'd1);
    chk("ar_gnt1", 8'(bif.gnt1), 8'd0);
    bif.req0 = 1'b0; bif.req1 = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
